// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load/fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // RISC-V "addi x0, x0, 0" returned in place of a faulting fetch
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam int          IMEM_DEPTH = 1024;
    localparam int          WORD_IDX_W = $clog2(IMEM_DEPTH);

endpackage

// File: rtl/imem_addr_check.sv
// Word alignment and window range check of a byte address against [BASE, BASE+4*2^IDX_W).
// Latency: purely combinational.
// Backpressure: none.
module imem_addr_check
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          IDX_W     = WORD_IDX_W
) (
    input  logic [31:0] addr,
    output logic        aligned,
    output logic        in_range
);

    logic [31:0] offset;

    // Window is a power of two, so any set bit above the word index means out of range
    always_comb begin
        offset   = addr - BASE_ADDR;
        aligned  = (addr[1:0] == 2'b00);
        in_range = (addr >= BASE_ADDR) && ((offset >> (IDX_W + 2)) == 32'd0);
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Arbitrates the single imem port: boot/reload word stream in LOAD, CPU fetch in RUN.
// Latency: writes and fetch data are same-cycle; done/err pulses are registered (+1 cycle).
// Backpressure: load_ready_o is high for the whole of LOAD; the CPU is stalled outside RUN.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH     = IMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LEN_W     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start_i,
    input  logic [LEN_W-1:0] load_len_i,
    input  logic [31:0]      load_data_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    output logic             load_busy_o,
    output logic             load_done_o,
    output logic             load_err_o,
    output logic [LEN_W-1:0] load_count_o,
    input  logic             fetch_req_i,
    input  logic [31:0]      fetch_addr_i,
    output logic [31:0]      fetch_inst_o,
    output logic             fetch_valid_o,
    output logic             fetch_err_o,
    output logic             cpu_stall_o,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      imem_wdata_o,
    output logic             imem_wr_en_o,
    input  logic [31:0]      imem_rdata_i
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic             done_q, err_q;
    logic             start_ok, err_set, done_set;
    logic             len_ok, last_word, accept;
    logic             fetch_aligned, fetch_in_range, fetch_ok, fetch_bad;
    logic [31:0]      load_addr;

    imem_addr_check #(
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     ($clog2(DEPTH))
    ) u_addr_check (
        .addr      (fetch_addr_i),
        .aligned   (fetch_aligned),
        .in_range  (fetch_in_range)
    );

    assign len_ok    = (load_len_i != '0) &&
                       ({{(32-LEN_W){1'b0}}, load_len_i} <= 32'(DEPTH));
    assign last_word = (count_q == len_q - LEN_W'(1));
    assign accept    = (state_q == LOAD) && load_valid_i;
    // count is zero-extended before scaling; len <= DEPTH keeps it inside the window
    assign load_addr = BASE_ADDR + ({{(32-LEN_W){1'b0}}, count_q} << 2);
    assign fetch_ok  = fetch_aligned && fetch_in_range;
    assign fetch_bad = fetch_req_i && !fetch_ok;

    assign load_done_o  = done_q;
    assign load_err_o   = err_q;
    assign load_count_o = count_q;

    // Next-state decode and per-state drive of the memory port and handshakes
    always_comb begin
        state_d       = state_q;
        start_ok      = 1'b0;
        err_set       = 1'b0;
        done_set      = 1'b0;
        load_ready_o  = 1'b0;
        load_busy_o   = 1'b0;
        cpu_stall_o   = 1'b1;
        imem_addr_o   = BASE_ADDR;
        imem_wdata_o  = '0;
        imem_wr_en_o  = 1'b0;
        fetch_valid_o = 1'b0;
        fetch_err_o   = 1'b0;
        fetch_inst_o  = '0;
        case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    if (len_ok) begin
                        start_ok = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        err_set  = 1'b1;
                    end
                end
            end
            LOAD: begin
                load_ready_o = 1'b1;
                load_busy_o  = 1'b1;
                imem_addr_o  = load_addr;
                imem_wdata_o = load_data_i;
                imem_wr_en_o = load_valid_i;
                // a start landing with the last word is dropped: the load completes
                if (load_valid_i && last_word) begin
                    done_set = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                cpu_stall_o   = 1'b0;
                imem_addr_o   = fetch_addr_i;
                fetch_valid_o = fetch_req_i && fetch_ok;
                fetch_err_o   = fetch_bad;
                fetch_inst_o  = fetch_bad ? NOP_INST : imem_rdata_i;
                if (load_start_i) begin
                    if (len_ok) begin
                        start_ok = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        err_set  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched length, word counter and registered status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_set;
            err_q   <= err_set;
            if (start_ok) begin
                len_q   <= load_len_i;
                count_q <= '0;
            end else if (accept) begin
                count_q <= count_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl with a behavioural memory and write scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_imem_load_ctrl;

    localparam int          LEN_W = 11;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_start_i;
    logic [LEN_W-1:0] load_len_i;
    logic [31:0]      load_data_i;
    logic             load_valid_i;
    logic             load_ready_o;
    logic             load_busy_o;
    logic             load_done_o;
    logic             load_err_o;
    logic [LEN_W-1:0] load_count_o;
    logic             fetch_req_i;
    logic [31:0]      fetch_addr_i;
    logic [31:0]      fetch_inst_o;
    logic             fetch_valid_o;
    logic             fetch_err_o;
    logic             cpu_stall_o;
    logic [31:0]      imem_addr_o;
    logic [31:0]      imem_wdata_o;
    logic             imem_wr_en_o;
    logic [31:0]      imem_rdata_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_e;
    logic [31:0] mem [0:1023];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          widx   = 0;

    imem_load_ctrl #(
        .DEPTH     (1024),
        .BASE_ADDR (BASE),
        .LEN_W     (LEN_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start_i  (load_start_i),
        .load_len_i    (load_len_i),
        .load_data_i   (load_data_i),
        .load_valid_i  (load_valid_i),
        .load_ready_o  (load_ready_o),
        .load_busy_o   (load_busy_o),
        .load_done_o   (load_done_o),
        .load_err_o    (load_err_o),
        .load_count_o  (load_count_o),
        .fetch_req_i   (fetch_req_i),
        .fetch_addr_i  (fetch_addr_i),
        .fetch_inst_o  (fetch_inst_o),
        .fetch_valid_o (fetch_valid_o),
        .fetch_err_o   (fetch_err_o),
        .cpu_stall_o   (cpu_stall_o),
        .imem_addr_o   (imem_addr_o),
        .imem_wdata_o  (imem_wdata_o),
        .imem_wr_en_o  (imem_wr_en_o),
        .imem_rdata_i  (imem_rdata_i)
    );

    always #5 clk = ~clk;

    // behavioural single-port memory: combinational read, write on rising edge
    assign imem_rdata_i = mem[imem_addr_o[11:2]];
    always @(posedge clk) begin
        if (imem_wr_en_o) mem[imem_addr_o[11:2]] <= imem_wdata_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // every write seen on the port must match the next scoreboard entry
    always @(negedge clk) begin
        if (imem_wr_en_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {31'b0, imem_wr_en_o}, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                chk("wr_addr", imem_addr_o, exp_e.addr);
                chk("wr_data", imem_wdata_o, exp_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int len);
        load_start_i = 1'b1;
        load_len_i   = LEN_W'(len);
        tick();
        load_start_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        exp_q.push_back({BASE + 32'(widx * 4), d});
        widx++;
        load_valid_i = 1'b1;
        load_data_i  = d;
        tick();
        load_valid_i = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] inst,
                         input logic vld, input logic err);
        fetch_req_i  = 1'b1;
        fetch_addr_i = a;
        #1;
        if (vld) chk({tag, "_inst"}, fetch_inst_o, inst);
        if (err) chk({tag, "_inst"}, fetch_inst_o, 32'h0000_0013);
        chk({tag, "_vld"}, {31'b0, fetch_valid_o}, {31'b0, vld});
        chk({tag, "_err"}, {31'b0, fetch_err_o}, {31'b0, err});
        fetch_req_i  = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (cpu_stall_o !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, cpu_stall_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        rst_n = 1'b0; load_start_i = 1'b0; load_len_i = '0; load_data_i = '0;
        load_valid_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 32'h0;
        #12;
        chk("rst_stall",  {31'b0, cpu_stall_o}, 32'd1);
        chk("rst_ready",  {31'b0, load_ready_o}, 32'd0);
        chk("rst_wr_en",  {31'b0, imem_wr_en_o}, 32'd0);
        chk("rst_addr",   imem_addr_o, BASE);
        chk("rst_wdata",  imem_wdata_o, 32'd0);
        chk("rst_count",  32'(load_count_o), 32'd0);
        chk("rst_done",   {31'b0, load_done_o}, 32'd0);
        chk("rst_err",    {31'b0, load_err_o}, 32'd0);
        chk("rst_fvld",   {31'b0, fetch_valid_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_fvld",  {31'b0, fetch_valid_o}, 32'd0);
        chk("idle_stall", {31'b0, cpu_stall_o}, 32'd1);
        fetch_req_i = 1'b0;

        // invalid length from IDLE
        start_load(0);
        chk("idle_len0_err",   {31'b0, load_err_o}, 32'd1);
        chk("idle_len0_busy",  {31'b0, load_busy_o}, 32'd0);
        tick();
        chk("idle_len0_pulse", {31'b0, load_err_o}, 32'd0);

        // boot load of 4 words with a one-cycle valid gap
        widx = 0;
        start_load(4);
        chk("ld4_busy",  {31'b0, load_busy_o}, 32'd1);
        chk("ld4_ready", {31'b0, load_ready_o}, 32'd1);
        chk("ld4_count0", 32'(load_count_o), 32'd0);
        send_word(32'hA0);
        send_word(32'hA1);
        tick();
        chk("ld4_gap_count", 32'(load_count_o), 32'd2);
        send_word(32'hA2);
        chk("ld4_done_early", {31'b0, load_done_o}, 32'd0);
        send_word(32'hA3);
        chk("ld4_done",  {31'b0, load_done_o}, 32'd1);
        chk("ld4_count", 32'(load_count_o), 32'd4);
        chk("ld4_run",   {31'b0, cpu_stall_o}, 32'd0);
        tick();
        chk("ld4_done_pulse", {31'b0, load_done_o}, 32'd0);
        chk("ld4_count_hold", 32'(load_count_o), 32'd4);

        fetch("f_0x8",    32'h8,    32'hA2, 1'b1, 1'b0);
        fetch("f_0x6",    32'h6,    32'h0,  1'b0, 1'b1);
        fetch("f_0x1000", 32'h1000, 32'h0,  1'b0, 1'b1);
        fetch("f_0xffc",  32'hFFC,  mem[1023], 1'b1, 1'b0);
        fetch("f_0xc",    32'hC,    32'hA3, 1'b1, 1'b0);

        // invalid lengths from RUN
        start_load(0);
        chk("run_len0_err",   {31'b0, load_err_o}, 32'd1);
        chk("run_len0_stall", {31'b0, cpu_stall_o}, 32'd0);
        tick();
        chk("run_len0_pulse", {31'b0, load_err_o}, 32'd0);
        start_load(1025);
        chk("run_len1025_err",   {31'b0, load_err_o}, 32'd1);
        chk("run_len1025_stall", {31'b0, cpu_stall_o}, 32'd0);
        tick();
        chk("run_len1025_pulse", {31'b0, load_err_o}, 32'd0);

        // reload of 2 words from RUN
        widx = 0;
        start_load(2);
        chk("rl_stall",  {31'b0, cpu_stall_o}, 32'd1);
        chk("rl_count0", 32'(load_count_o), 32'd0);
        send_word(32'hB0);
        send_word(32'hB1);
        wait_run("rl_run");
        chk("rl_count", 32'(load_count_o), 32'd2);
        fetch("rl_f_0x4", 32'h4, 32'hB1, 1'b1, 1'b0);
        fetch("rl_f_0x8", 32'h8, 32'hA2, 1'b1, 1'b0);

        // reset in the middle of a 5-word load
        widx = 0;
        start_load(5);
        send_word(32'hC0);
        send_word(32'hC1);
        load_valid_i = 1'b1;
        load_data_i  = 32'hC2;
        rst_n = 1'b0;
        #1;
        chk("mrst_stall", {31'b0, cpu_stall_o}, 32'd1);
        chk("mrst_count", 32'(load_count_o), 32'd0);
        chk("mrst_ready", {31'b0, load_ready_o}, 32'd0);
        chk("mrst_wr_en", {31'b0, imem_wr_en_o}, 32'd0);
        tick();
        tick();
        load_valid_i = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("mrst_idle_stall", {31'b0, cpu_stall_o}, 32'd1);
        chk("mrst_idle_busy",  {31'b0, load_busy_o}, 32'd0);

        // fresh 5-word load: start ignored in LOAD, start coincident with last word
        widx = 0;
        start_load(5);
        send_word(32'hD0);
        load_start_i = 1'b1;
        load_len_i   = '0;
        tick();
        load_start_i = 1'b0;
        chk("ld5_ign_err",   {31'b0, load_err_o}, 32'd0);
        chk("ld5_ign_busy",  {31'b0, load_busy_o}, 32'd1);
        chk("ld5_ign_count", 32'(load_count_o), 32'd1);
        send_word(32'hD1);
        send_word(32'hD2);
        send_word(32'hD3);
        exp_q.push_back({BASE + 32'(widx * 4), 32'hD4});
        widx++;
        load_valid_i = 1'b1;
        load_data_i  = 32'hD4;
        load_start_i = 1'b1;
        load_len_i   = LEN_W'(3);
        tick();
        load_valid_i = 1'b0;
        load_start_i = 1'b0;
        chk("ld5_done",  {31'b0, load_done_o}, 32'd1);
        chk("ld5_count", 32'(load_count_o), 32'd5);
        chk("ld5_run",   {31'b0, cpu_stall_o}, 32'd0);
        tick();
        chk("ld5_still_run",  {31'b0, cpu_stall_o}, 32'd0);
        chk("ld5_count_hold", 32'(load_count_o), 32'd5);
        fetch("ld5_f_0x10", 32'h10, 32'hD4, 1'b1, 1'b0);
        fetch("ld5_f_0x0",  32'h0,  32'hD0, 1'b1, 1'b0);

        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Owns the single port of the instruction memory and shares it between a program loader (valid/ready word stream) and CPU instruction fetch. After reset it holds the CPU stalled and sequences a boot load of N words into consecutive word addresses from BASE_ADDR. It then hands the port to fetch, with address-range and alignment checking. A reload can be requested at any time from RUN.

Parameters:
DEPTH, 1024, instruction memory depth in 32-bit words (power of two)
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word (word-aligned)
LEN_W, 11, width of the load length/count fields (must hold DEPTH)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
load_start_i  in  1  single-cycle request to begin a load
load_len_i  in  LEN_W  number of words to load; sampled when load_start_i is high
load_data_i  in  32  instruction word from the loader
load_valid_i  in  1  load_data_i is valid
load_ready_o  out  1  controller accepts a word this cycle
load_busy_o  out  1  high while in LOAD
load_done_o  out  1  one-cycle pulse when the last word is written
load_err_o  out  1  one-cycle pulse when a load request is rejected
load_count_o  out  LEN_W  words written in the current or last load
fetch_req_i  in  1  CPU fetch request
fetch_addr_i  in  32  CPU fetch byte address
fetch_inst_o  out  32  fetched instruction, combinational from imem_rdata_i
fetch_valid_o  out  1  fetch_inst_o is valid this cycle
fetch_err_o  out  1  fetch was misaligned or out of range
cpu_stall_o  out  1  CPU must hold its PC
imem_addr_o  out  32  byte address to the memory
imem_wdata_o  out  32  write data to the memory
imem_wr_en_o  out  1  memory write enable; the write lands on the next rising clk edge
imem_rdata_i  in  32  combinational read data from the memory

Behaviour:
- Reset values (asserted asynchronously): state=IDLE, count=0, load_ready_o=0, load_busy_o=0, load_done_o=0, load_err_o=0, fetch_valid_o=0, fetch_err_o=0, cpu_stall_o=1, imem_wr_en_o=0, imem_addr_o=BASE_ADDR, imem_wdata_o=0.
- Memory contents are not cleared by reset.
- States: IDLE, LOAD, RUN.
- IDLE: cpu_stall_o=1; fetch outputs are 0.
  - load_start_i with 1<=load_len_i<=DEPTH latches len, clears count and moves to LOAD next cycle.
  - load_len_i==0 or load_len_i>DEPTH pulses load_err_o next cycle and stays in IDLE.
- LOAD: load_ready_o=1, load_busy_o=1, cpu_stall_o=1.
  - imem_addr_o = BASE_ADDR + 4*count.
  - imem_wdata_o = load_data_i.
  - imem_wr_en_o = load_valid_i (combinational, same cycle).
  - Each accepted word (valid&ready) increments count at the clock edge.
  - The cycle the word with count==len-1 is accepted, next state is RUN and load_done_o pulses for exactly one cycle.
  - load_start_i in LOAD is ignored, with no error pulse.
  - Gaps in load_valid_i are allowed; no timeout.
- RUN: cpu_stall_o=0, load_ready_o=0, imem_wr_en_o=0, imem_addr_o=fetch_addr_i.
  - fetch_valid_o = fetch_req_i & aligned & in_range.
  - fetch_inst_o = imem_rdata_i. This is zero latency, same cycle.
  - fetch_err_o = fetch_req_i & (fetch_addr_i[1:0]!=0 | word index (fetch_addr_i-BASE_ADDR)>>2 >= DEPTH | fetch_addr_i<BASE_ADDR).
  - On error, fetch_inst_o is forced to 32'h0000_0013 (NOP) and fetch_valid_o=0.
  - load_start_i in RUN applies the same validity check as IDLE. A valid request goes to LOAD with cpu_stall_o=1 from the next cycle. An invalid one pulses load_err_o and stays in RUN.
- Address arithmetic: count is zero-extended to 32 bits before the multiply by 4. It never wraps, because len<=DEPTH.
- Reset mid-load: returns to IDLE immediately. The partial load is discarded logically; count reads 0 and the CPU stays stalled.
- Simultaneous last-word accept and load_start_i: the load completes and load_start_i is ignored.
- load_count_o holds its final value after done until the next accepted start.

Decomposition:
- Shared package imem_pkg holds:
  - state enum {IDLE, LOAD, RUN}
  - NOP_INST = 32'h0000_0013
  - IMEM_DEPTH default
  - word-index helper width WORD_IDX_W = log2(DEPTH)
- One natural sub-module: imem_addr_check (combinational alignment/range check, reused by data-memory work later).
- The FSM and counter stay in the top.

Test Plan:
- Reset then idle: cpu_stall_o=1, fetch_req_i=1 at 0x0 -> fetch_valid_o=0, load_ready_o=0.
- Load 4 words 0xA0..0xA3 with a one-cycle valid gap, BASE_ADDR=0:
  - writes land at 0x0,0x4,0x8,0xC
  - load_done_o pulses once after the 4th accept
  - load_count_o=4
  - RUN next cycle
- RUN fetch at 0x8 -> same-cycle fetch_inst_o=0xA2, fetch_valid_o=1. Fetch at 0x6 -> fetch_err_o=1, fetch_inst_o=0x13. Fetch at 0x1000 -> fetch_err_o=1.
- load_start_i with len=0 and with len=1025 -> load_err_o single pulse, state unchanged, no write.
- Reload from RUN with len=2 -> cpu_stall_o=1 next cycle, words written to 0x0/0x4, back to RUN.
- rst_n low after 2 of 5 words -> immediate IDLE, count=0, stall=1, no further writes; a fresh load of 5 completes normally.
